// File: rtl/slot_buffer_pkg.sv
// Shared definitions for the slot buffer: operating modes and status bit positions.
package slot_buffer_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_SUM    = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    localparam int unsigned ST_FULL  = 2;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_SAT   = 0;

endpackage

// File: rtl/slot_next_valid.sv
// Wrap-around search of a valid vector: first set bit at or after start_i, modulo DEPTH.
module slot_next_valid
    import slot_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // DEPTH is a power of two, so the index add wraps naturally
            cand = start_i + IDX_W'(i);
            if (!found_o && valid_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/slot_buffer_ctrl.sv
// Multi-slot data buffer with edge-triggered submit and direct/scan/sum/count readout.
// Optional SUBMIT_SYNC_EN: submit passes through a 2-flop synchronizer before edge detection.
module slot_buffer_ctrl
    import slot_buffer_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IDX_W    = $clog2(DEPTH),
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              submit,
    input  logic [IDX_W-1:0]  buffer_index,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] out,
    output logic [2:0]        status
);

    localparam int unsigned SUM_W = DATA_W + IDX_W;
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'({DATA_W{1'b1}});

    mode_e             mode_s;
    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              submit_q, armed_q;
    logic              submit_s, arm_ok, fire;
    logic [DATA_W-1:0] out_q, out_d;
    logic [2:0]        status_q, status_d;
    logic [SUM_W-1:0]  sum;
    logic [IDX_W:0]    count;
    logic              nv_found;
    logic [IDX_W-1:0]  nv_idx, scan_start;

    assign mode_s = mode_e'(mode);

`ifdef SUBMIT_SYNC_EN
    logic sync1_q, sync2_q, live_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            sync1_q <= submit;
            sync2_q <= sync1_q;
            live_q  <= 1'b1;
        end
    end

    assign submit_s = sync2_q;
    assign arm_ok   = live_q & ~sync1_q;
`else
    assign submit_s = submit;
    assign arm_ok   = ~submit;
`endif

    // Edge detection is armed only once submit has been seen low after reset,
    // so a submit held high through reset release cannot fire.
    assign fire = submit_s & ~submit_q & armed_q;

    assign scan_start = ptr_q + IDX_W'(1);

    slot_next_valid #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_next_valid (
        .valid_i (valid_q),
        .start_i (scan_start),
        .found_o (nv_found),
        .idx_o   (nv_idx)
    );

    always_comb begin
        sum   = '0;
        count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                sum   = sum + SUM_W'(slot_q[i]);
                count = count + (IDX_W+1)'(1);
            end
        end
    end

    always_comb begin
        out_d = '0;
        unique case (mode_s)
            MODE_DIRECT: out_d = valid_q[buffer_index] ? slot_q[buffer_index] : '0;
            MODE_SCAN:   out_d = valid_q[ptr_q] ? slot_q[ptr_q] : '0;
            MODE_SUM:    out_d = (sum > SUM_MAX) ? '1 : DATA_W'(sum);
            MODE_CLEAR:  out_d = DATA_W'(count);
            default:     out_d = '0;
        endcase

        status_d           = '0;
        status_d[ST_FULL]  = &valid_q;
        status_d[ST_EMPTY] = ~|valid_q;
        status_d[ST_SAT]   = sum > SUM_MAX;
    end

    // Scan search runs on the pre-write valid vector
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (mode_s == MODE_SCAN) begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_d = '0;
                if (nv_found) ptr_d = nv_idx;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q   <= '{default: '0};
            valid_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            submit_q <= 1'b0;
            armed_q  <= 1'b0;
            out_q    <= '0;
            status_q <= 3'b010;
        end else begin
            submit_q <= submit_s;
            armed_q  <= armed_q | arm_ok;
            out_q    <= out_d;
            status_q <= status_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            if (fire) begin
                if (mode_s == MODE_CLEAR) begin
                    valid_q[buffer_index] <= 1'b0;
                end else begin
                    slot_q[buffer_index]  <= data;
                    valid_q[buffer_index] <= 1'b1;
                end
            end
        end
    end

    assign out    = out_q;
    assign status = status_q;

endmodule

// File: tb/tb_slot_buffer_ctrl.sv
// Self-checking bench for slot_buffer_ctrl against a behavioural slot/valid model.
module tb_slot_buffer_ctrl;

    localparam int DW  = 4;
    localparam int DEP = 4;
    localparam int SD  = 4;
`ifdef SUBMIT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          submit = 1'b0;
    logic [1:0]    idx = '0;
    logic [DW-1:0] data = '0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] out;
    logic [2:0]    status;

    int checks = 0;
    int fails  = 0;

    // behavioural model state
    int         m_slot [DEP];
    bit         m_valid [DEP];
    int         m_ptr, m_cnt;
    bit         m_sq, m_armed, m_s1, m_s2;
    logic [3:0] m_out;
    logic [2:0] m_status;

    slot_buffer_ctrl #(.DATA_W(DW), .DEPTH(DEP), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .submit(submit), .buffer_index(idx),
        .data(data), .mode(mode), .out(out), .status(status)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < DEP; i++) begin m_slot[i] = 0; m_valid[i] = 0; end
        m_ptr = 0; m_cnt = 0; m_sq = 0; m_armed = 0; m_s1 = 0; m_s2 = 0;
        m_out = 0; m_status = 3'b010;
    endfunction

    function automatic void model_edge();
        int sum, n, s_eff, k;
        bit fire, found;
        if (!reset) return;
        sum = 0; n = 0;
        for (int i = 0; i < DEP; i++) if (m_valid[i]) begin sum += m_slot[i]; n++; end
        case (mode)
            2'd0: m_out = m_valid[idx] ? 4'(m_slot[idx]) : 4'd0;
            2'd1: m_out = m_valid[m_ptr] ? 4'(m_slot[m_ptr]) : 4'd0;
            2'd2: m_out = (sum > 15) ? 4'd15 : 4'(sum);
            default: m_out = 4'(n % 16);
        endcase
        m_status = {n == DEP, n == 0, sum > 15};
`ifdef SUBMIT_SYNC_EN
        s_eff = int'(m_s2);
`else
        s_eff = int'(submit);
`endif
        fire = (s_eff == 1) && !m_sq && m_armed;
        if (mode == 2'd1) begin
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                found = 0;
                for (int j = 1; j <= DEP; j++) begin
                    k = (m_ptr + j) % DEP;
                    if (!found && m_valid[k]) begin m_ptr = k; found = 1; end
                end
            end else begin
                m_cnt++;
            end
        end
        if (fire) begin
            if (mode == 2'd3) m_valid[idx] = 0;
            else begin m_slot[idx] = int'(data); m_valid[idx] = 1; end
        end
        if (!submit) m_armed = 1;
        m_s2 = m_s1;
        m_s1 = submit;
        m_sq = (s_eff == 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse(input int i, input int d, input int md);
        idx = 2'(i); data = 4'(d); mode = 2'(md); submit = 1'b1;
        repeat (LAT + 1) tick();
        submit = 1'b0;
        repeat (LAT + 1) tick();
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) tick();
        checks++;
        if ({out, status} !== {4'd0, 3'b010}) begin
            fails++;
            $display("FAIL reset_state out=%0d status=%b required out=0 status=010", out, status);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_write_hold();
        mode = 2'd0; idx = 2'd2; data = 4'd9; submit = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({out, status} !== {m_out, m_status}) begin
                fails++;
                $display("FAIL write_hold_model c=%0d out=%0d status=%b required %0d %b", c, out, status, m_out, m_status);
            end
            if (c == LAT) begin
                checks++;
                if (out !== 4'd0) begin fails++; $display("FAIL write_latency_early out=%0d required 0", out); end
                data = 4'd5;
            end
            if (c == LAT + 1) begin
                checks++;
                if (out !== 4'd9) begin fails++; $display("FAIL write_latency out=%0d required 9", out); end
            end
            if (c == 4) submit = 1'b0;
        end
        checks++;
        if ({out, status} !== {4'd9, 3'b000}) begin
            fails++;
            $display("FAIL single_write out=%0d status=%b required out=9 status=000", out, status);
        end
    endtask

    task automatic test_sum_sat();
        for (int i = 0; i < DEP; i++) pulse(i, i + 1, 0);
        mode = 2'd2;
        repeat (2) tick();
        checks++;
        if ({out, status} !== {4'd10, 3'b100}) begin
            fails++;
            $display("FAIL sum_full out=%0d status=%b required out=10 status=100", out, status);
        end
        pulse(3, 15, 0);
        mode = 2'd2;
        repeat (2) tick();
        checks++;
        if ({out, status} !== {4'd15, 3'b101}) begin
            fails++;
            $display("FAIL sum_clamp out=%0d status=%b required out=15 status=101", out, status);
        end
    endtask

    task automatic test_scan();
        do_reset();
        pulse(0, 6, 0);
        pulse(2, 11, 0);
        mode = 2'd1;
        for (int c = 0; c < 24; c++) begin
            tick();
            checks++;
            if ({out, status} !== {m_out, m_status} || (out !== 4'd6 && out !== 4'd11)) begin
                fails++;
                $display("FAIL scan_seq c=%0d out=%0d status=%b required %0d %b", c, out, status, m_out, m_status);
            end
        end
        for (int i = 0; i < DEP; i++) pulse(i, 0, 3);
        mode = 2'd1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({out, status} !== {4'd0, 3'b010} || {out, status} !== {m_out, m_status}) begin
                fails++;
                $display("FAIL scan_empty c=%0d out=%0d status=%b required out=0 status=010", c, out, status);
            end
        end
    endtask

    task automatic test_clear_count();
        for (int i = 0; i < DEP; i++) pulse(i, i + 1, 0);
        pulse(1, 0, 3);
        mode = 2'd3;
        repeat (2) tick();
        checks++;
        if ({out, status} !== {4'd3, 3'b000}) begin
            fails++;
            $display("FAIL clear_count out=%0d status=%b required out=3 status=000", out, status);
        end
        mode = 2'd0; idx = 2'd1;
        repeat (2) tick();
        checks++;
        if (out !== 4'd0 || out !== m_out) begin
            fails++;
            $display("FAIL cleared_direct out=%0d required 0", out);
        end
    endtask

    task automatic test_reset_mid_scan();
        mode = 2'd1;
        repeat (5) tick();
        submit = 1'b1; idx = 2'd3; data = 4'd2;
        repeat (LAT + 2) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out, status} !== {4'd0, 3'b010}) begin
            fails++;
            $display("FAIL async_reset out=%0d status=%b required out=0 status=010", out, status);
        end
        idx = 2'd1; data = 4'd7; mode = 2'd0;
        repeat (2) tick();
        reset = 1'b1;
        for (int c = 0; c < LAT + 6; c++) begin
            tick();
            checks++;
            if (out !== 4'd0 || {out, status} !== {m_out, m_status}) begin
                fails++;
                $display("FAIL held_submit_no_fire c=%0d out=%0d status=%b required out=0 status=%b", c, out, status, m_status);
            end
        end
        submit = 1'b0;
        repeat (LAT + 2) tick();
        submit = 1'b1;
        repeat (LAT + 2) tick();
        checks++;
        if ({out, status} !== {4'd7, 3'b000}) begin
            fails++;
            $display("FAIL fire_after_release out=%0d status=%b required out=7 status=000", out, status);
        end
        submit = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            mode = 2'($urandom_range(0, 3));
            idx  = 2'($urandom_range(0, DEP - 1));
            data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) submit = ~submit;
            tick();
            checks++;
            if ({out, status} !== {m_out, m_status}) begin
                fails++;
                $display("FAIL random c=%0d out=%0d status=%b required %0d %b", c, out, status, m_out, m_status);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_hold();
        test_sum_sat();
        test_scan();
        test_clear_count();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
